// File: rtl/timer_counter_if.sv
// timer_counter_if: control/status bundle between the control FSM and the timer
// master: drives clr/load/enable/load_value, observes count/tc/busy/done/expire_cnt
// slave:  the timer side of the same signals
interface timer_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             clr;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;
  logic [7:0]       expire_cnt;
  modport master (
    output clr, load, enable, load_value,
    input  count, tc, busy, done, expire_cnt
  );
  modport slave (
    input  clr, load, enable, load_value,
    output count, tc, busy, done, expire_cnt
  );
endinterface

// File: rtl/timer_counter.sv
// timer_counter: loadable down-counter with terminal-count pulse and optional auto-reload
// clk, reset (async, active-high) plus bus (slave):
//   in  clr, load, enable, load_value ; out count, tc, busy, done, expire_cnt
module timer_counter #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [7:0]       exp_q, exp_d;
  logic             last;
  // a count of 1 or 0 expires on the next enabled edge
  assign last = count_q[WIDTH-1:1] == '0;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    exp_d    = exp_q;
    if (bus.clr) begin
      state_d  = IDLE;
      count_d  = '0;
      reload_d = '0;
      exp_d    = '0;
    end else if (bus.load) begin
      state_d  = IDLE;
      count_d  = bus.load_value;
      reload_d = bus.load_value;
    end else if (bus.enable && state_q != DONE) begin
      if (!last) begin
        count_d = count_q - WIDTH'(1);
        state_d = RUN;
      end else begin
        tc_d  = 1'b1;
        exp_d = exp_q + 8'(exp_q != 8'hff);
        if (AUTO_RELOAD && reload_q != '0) begin
          count_d = reload_q;
          state_d = RUN;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end else if (!bus.enable && state_q == RUN) begin
      state_d = PAUSE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      exp_q    <= exp_d;
    end
  end
  assign bus.count      = count_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = state_q == RUN || state_q == PAUSE;
  assign bus.done       = state_q == DONE;
  assign bus.expire_cnt = exp_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: random and directed checks of timer_counter (both reload modes) against a model
module tb_timer_counter;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  timer_counter_if #(.WIDTH(8)) b0 ();
  timer_counter_if #(.WIDTH(8)) b1 ();

  timer_counter #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  timer_counter #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase is 'I'dle, 'R'unning, 'P'aused or 'D'one; index = auto-reload setting
  int  m_cnt[2], m_rel[2], m_exp[2];
  bit  m_tc[2];
  byte m_ph[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_exp[k] = 0; m_tc[k] = 1'b0; m_ph[k] = "I";
    end
  endtask

  task automatic model_edge(input int k, input bit c, input bit l, input bit e, input int v);
    m_tc[k] = 1'b0;
    if (c) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_exp[k] = 0; m_ph[k] = "I";
    end else if (l) begin
      m_cnt[k] = v; m_rel[k] = v; m_ph[k] = "I";
    end else if (e && m_ph[k] != "D") begin
      if (m_cnt[k] > 1) begin
        m_cnt[k] = m_cnt[k] - 1; m_ph[k] = "R";
      end else begin
        m_tc[k]  = 1'b1;
        m_exp[k] = (m_exp[k] < 255) ? m_exp[k] + 1 : 255;
        if (k == 1 && m_rel[k] != 0) begin
          m_cnt[k] = m_rel[k]; m_ph[k] = "R";
        end else begin
          m_cnt[k] = 0; m_ph[k] = "D";
        end
      end
    end else if (m_ph[k] == "R") begin
      m_ph[k] = "P";
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s cnt0", tag), b0.count, m_cnt[0]);
    chk($sformatf("%s tc0", tag), b0.tc, m_tc[0]);
    chk($sformatf("%s busy0", tag), b0.busy, m_ph[0] == "R" || m_ph[0] == "P");
    chk($sformatf("%s done0", tag), b0.done, m_ph[0] == "D");
    chk($sformatf("%s exp0", tag), b0.expire_cnt, m_exp[0]);
    chk($sformatf("%s cnt1", tag), b1.count, m_cnt[1]);
    chk($sformatf("%s tc1", tag), b1.tc, m_tc[1]);
    chk($sformatf("%s busy1", tag), b1.busy, m_ph[1] == "R" || m_ph[1] == "P");
    chk($sformatf("%s done1", tag), b1.done, m_ph[1] == "D");
    chk($sformatf("%s exp1", tag), b1.expire_cnt, m_exp[1]);
  endtask

  task automatic step(input string tag, input bit c, input bit l, input bit e, input int v);
    b0.clr = c; b0.load = l; b0.enable = e; b0.load_value = 8'(v);
    b1.clr = c; b1.load = l; b1.enable = e; b1.load_value = 8'(v);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_edge(k, c, l, e, v);
    check_all(tag);
  endtask

  // asynchronous pulse placed between edges; outputs must clear before the next edge
  task automatic async_reset(input string tag);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b0.clr = 0; b0.load = 0; b0.enable = 0; b0.load_value = 0;
    b1.clr = 0; b1.load = 0; b1.enable = 0; b1.load_value = 0;
    model_reset();
    #1 check_all("reset");
    #2 reset = 1'b0;

    // directed: basic countdown, then enable ignored in DONE
    step("t1 load", 0, 1, 0, 5);
    for (int i = 0; i < 7; i++) step("t1 run", 0, 0, 1, 0);
    // directed: auto-reload period 3
    step("t2 load", 0, 1, 0, 3);
    for (int i = 0; i < 9; i++) step("t2 run", 0, 0, 1, 0);
    // directed: pause and resume
    step("t3 load", 0, 1, 0, 6);
    for (int i = 0; i < 2; i++) step("t3 run", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("t3 pause", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("t3 resume", 0, 0, 1, 0);
    // directed: clr, then load wins over enable
    step("t4 load", 0, 1, 0, 10);
    for (int i = 0; i < 4; i++) step("t4 run", 0, 0, 1, 0);
    step("t4 clr", 1, 0, 1, 0);
    step("t4 load+en", 0, 1, 1, 7);
    step("t4 run", 0, 0, 1, 0);
    // directed: load 0 expires immediately
    step("t5 load0", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("t5 run", 0, 0, 1, 0);
    // directed: async reset mid-count
    step("t6 load", 0, 1, 0, 6);
    step("t6 run", 0, 0, 1, 0);
    step("t6 run", 0, 0, 1, 0);
    async_reset("t6 areset");
    step("t6 after", 0, 0, 1, 0);
    // directed: expiry counter saturation
    step("t6 load1", 0, 1, 0, 1);
    for (int i = 0; i < 300; i++) step("t6 sat", 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int  r;
      bit  c, l, e;
      int  v;
      r = $urandom_range(0, 999);
      c = r < 25;
      l = $urandom_range(0, 99) < 10;
      e = $urandom_range(0, 99) < 75;
      v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      if (r > 990) async_reset("rnd areset");
      step("rnd", c, l, e, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
